// File: rtl/rom_stream_reader_if.sv
// Control, ROM-side and stream-side signal bundle for rom_stream_reader.
interface rom_stream_reader_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_en;
  logic [WIDTH-1:0]      rom_rdata;
  logic [WIDTH-1:0]      m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base, len, rom_rdata, m_ready,
    output busy, done, rom_addr, rom_en, m_data, m_valid
  );

  modport slave (
    output start, base, len, rom_rdata, m_ready,
    input  busy, done, rom_addr, rom_en, m_data, m_valid
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Burst reader for a 1-cycle-latency ROM, streamed out through a 2-entry skid FIFO.
// Optional running checksum of accepted words: define ROM_READER_CHECKSUM_EN.
module rom_stream_reader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef ROM_READER_CHECKSUM_EN
  output logic [WIDTH-1:0] checksum,
`endif
  rom_stream_reader_if.master bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  accepted_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic [WIDTH-1:0]      fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  take_start;
  logic                  latch;
  logic                  issue;
  logic                  done_d;
  logic                  push;
  logic                  pop;
  logic                  m_valid;
  logic [WIDTH-1:0]      m_data;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign m_valid    = (count_q != 2'd0);
  assign m_data     = fifo_q[rd_ptr_q];
  assign pop        = m_valid & bus.m_ready;
  assign push       = inflight_q;
  assign take_start = (state_q == IDLE) && bus.start;
  // Words already committed to the FIFO slots: stored plus the one coming back from the ROM.
  assign occupancy  = 3'(count_q) + 3'(inflight_q);
  assign addr_next  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = READ;
          end
        end
      end
      READ: begin
        issue = (issued_q < len_q) && (occupancy < (3'd2 + 3'(pop)));
        if (issue && ((issued_q + LEN_WIDTH'(1)) == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && ((accepted_q + LEN_WIDTH'(1)) == len_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and skid FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      inflight_q <= issue;
      if (latch) begin
        len_q      <= bus.len;
        addr_q     <= bus.base;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_next;
          issued_q <= issued_q + LEN_WIDTH'(1);
        end
        if (pop) accepted_q <= accepted_q + LEN_WIDTH'(1);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.rom_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q;

  // Running sum of accepted words, restarted by every accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sum_q <= '0;
    else if (take_start) sum_q <= '0;
    else if (pop)        sum_q <= sum_q + m_data;
  end

  assign checksum = sum_q;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rom_addr = addr_q;
  assign bus.rom_en   = issue;
  assign bus.m_data   = m_data;
  assign bus.m_valid  = m_valid;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: hand sequences for timing/reset corners plus a burst table.
`timescale 1ns/1ps
module tb_rom_stream_reader;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned LW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef ROM_READER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  rom_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ROM_READER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (bus)
  );

  // ROM model: word i holds i, registered read
  logic [WIDTH-1:0] rom [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) rom[i] = WIDTH'(i);
  always @(posedge clk) if (bus.rom_en) bus.rom_rdata <= rom[bus.rom_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [15:0]   ready;     // m_ready per cycle, bit (cycle % 16)
    logic [15:0]   exp_sum;
    logic [15:0]   exp_last;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int idx);
    vec_t        v;
    int          cyc, got, issued;
    logic [15:0] sum, last, stall_data;
    logic        stalled, done_seen, pop;
    v = vecs[idx];
    @(negedge clk);
    bus.start = 1'b1; bus.base = v.base; bus.len = v.len; bus.m_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.base = ~v.base; bus.len = LW'(5);
    cyc = 0; got = 0; issued = 0; sum = '0; last = '0;
    stalled = 1'b0; stall_data = '0; done_seen = 1'b0;
    while (!done_seen && cyc < 1000) begin
      bus.m_ready = v.ready[cyc % 16];
      #1;
      pop = bus.m_valid & bus.m_ready;
      if (stalled) begin
        check($sformatf("v%0d_stall_valid", idx), 32'(bus.m_valid), 1);
        check($sformatf("v%0d_stall_data", idx), 32'(bus.m_data), 32'(stall_data));
      end
      if (bus.rom_en) begin
        check($sformatf("v%0d_rom_addr", idx), 32'(bus.rom_addr), 32'((v.base + issued) % DEPTH));
        check($sformatf("v%0d_credit", idx), 32'((issued - got - int'(pop)) < 2), 1);
        issued++;
      end
      if (pop) begin
        check($sformatf("v%0d_data%0d", idx, got), 32'(bus.m_data), 32'((v.base + got) % DEPTH));
        sum  = sum + bus.m_data;
        last = bus.m_data;
        got++;
      end
      stalled    = bus.m_valid & ~bus.m_ready;
      stall_data = bus.m_data;
      if (bus.done) done_seen = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    check($sformatf("v%0d_done_seen", idx), 32'(done_seen), 1);
    check($sformatf("v%0d_words", idx), 32'(got), 32'(v.len));
    check($sformatf("v%0d_issues", idx), 32'(issued), 32'(v.len));
    check($sformatf("v%0d_sum", idx), 32'(sum), 32'(v.exp_sum));
    check($sformatf("v%0d_last", idx), 32'(last), 32'(v.exp_last));
    check($sformatf("v%0d_busy_at_done", idx), 32'(bus.busy), 0);
`ifdef ROM_READER_CHECKSUM_EN
    check($sformatf("v%0d_checksum", idx), 32'(checksum), 32'(v.exp_sum));
`endif
    @(negedge clk);
    #1;
    check($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 0);
  endtask

  initial begin
    int acc;
    vecs[0] = '{base: 6'd0,  len: 7'd4,  ready: 16'hFFFF, exp_sum: 16'd6,    exp_last: 16'd3};
    vecs[1] = '{base: 6'd62, len: 7'd4,  ready: 16'hFFFF, exp_sum: 16'd126,  exp_last: 16'd1};
    vecs[2] = '{base: 6'd5,  len: 7'd8,  ready: 16'h9999, exp_sum: 16'd68,   exp_last: 16'd12};
    vecs[3] = '{base: 6'd60, len: 7'd8,  ready: 16'h35A6, exp_sum: 16'd252,  exp_last: 16'd3};
    vecs[4] = '{base: 6'd0,  len: 7'd64, ready: 16'hFFFF, exp_sum: 16'd2016, exp_last: 16'd63};
    vecs[5] = '{base: 6'd10, len: 7'd1,  ready: 16'h0F0E, exp_sum: 16'd10,   exp_last: 16'd10};

    bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.m_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rom_en", 32'(bus.rom_en), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_m_data", 32'(bus.m_data), 0);
`ifdef ROM_READER_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // base 0, len 4, ready high: exact cycle timing, and a start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.base = '0; bus.len = LW'(4); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("t_busy", 32'(bus.busy), 1);
    check("t_rom_en1", 32'(bus.rom_en), 1);
    check("t_addr1", 32'(bus.rom_addr), 0);
    check("t_valid1", 32'(bus.m_valid), 0);
    @(negedge clk);
    #1;
    check("t_valid2", 32'(bus.m_valid), 0);
    check("t_addr2", 32'(bus.rom_addr), 1);
    bus.start = 1'b1; bus.base = AW'(30); bus.len = LW'(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check($sformatf("t_valid_w%0d", k), 32'(bus.m_valid), 1);
      check($sformatf("t_data_w%0d", k), 32'(bus.m_data), 32'(k));
      check($sformatf("t_done_w%0d", k), 32'(bus.done), 0);
    end
    @(negedge clk);
    #1;
    check("t_done", 32'(bus.done), 1);
    check("t_busy_end", 32'(bus.busy), 0);
    check("t_valid_end", 32'(bus.m_valid), 0);
    @(negedge clk);
    #1;
    check("t_done_low", 32'(bus.done), 0);
    check("t_rom_en_idle", 32'(bus.rom_en), 0);
    check("t_addr_hold", 32'(bus.rom_addr), 4);
    check("t_no_restart", 32'(bus.busy), 0);

    // len 0: no ROM access, done one cycle later
    @(negedge clk);
    bus.start = 1'b1; bus.base = AW'(9); bus.len = '0;
    #1;
    check("z_rom_en0", 32'(bus.rom_en), 0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("z_done", 32'(bus.done), 1);
    check("z_busy", 32'(bus.busy), 0);
    check("z_rom_en1", 32'(bus.rom_en), 0);
    @(negedge clk);
    #1;
    check("z_done_low", 32'(bus.done), 0);
    check("z_valid", 32'(bus.m_valid), 0);

    // Reset after two words of a 10-word burst
    @(negedge clk);
    bus.start = 1'b1; bus.base = AW'(20); bus.len = LW'(10); bus.m_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) acc++;
      if (acc < 2) @(negedge clk);
    end
    check("r_two_words", 32'(acc), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("r_busy", 32'(bus.busy), 0);
    check("r_done", 32'(bus.done), 0);
    check("r_rom_en", 32'(bus.rom_en), 0);
    check("r_valid", 32'(bus.m_valid), 0);
    check("r_data", 32'(bus.m_data), 0);
    check("r_addr", 32'(bus.rom_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("r_quiet%0d", c), 32'({bus.done, bus.m_valid, bus.busy, bus.rom_en}), 0);
    end

    for (int i = 0; i < 6; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
